// File: rtl/mem_req_rsp_ctrl_if.sv
// Request/response bus between a requester (master) and mem_req_rsp_ctrl (slave).
// Defining MEMIF_BYTE_STROBE_EN adds req_wstrb_i, one write-enable bit per byte.
interface mem_req_rsp_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  // Both channels use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high. The sender keeps valid and its payload stable until that edge.
  logic              req_valid_i;
  logic              req_rnw_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
`ifdef MEMIF_BYTE_STROBE_EN
  logic [DATA_W/8-1:0] req_wstrb_i;
`endif
  logic              req_ready_o;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport slave (
`ifdef MEMIF_BYTE_STROBE_EN
    input  req_wstrb_i,
`endif
    input  req_valid_i, req_rnw_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
`ifdef MEMIF_BYTE_STROBE_EN
    output req_wstrb_i,
`endif
    output req_valid_i, req_rnw_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/mem_req_rsp_ctrl.sv
// Single-port memory controller with LFSR-driven request wait states and a held read response.
// Defining MEMIF_BYTE_STROBE_EN enables per-byte write strobes from the interface.
module mem_req_rsp_ctrl #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter int          WAIT_W    = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hE1
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_req_rsp_ctrl_if.slave      bus,
  output logic [1:0]             dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [7:0]        lfsr_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_ready, rsp_valid, wr_en, addr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  assign addr_ok = ({1'b0, bus.req_addr_i} < DEPTH_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // x^8+x^6+x^5+x^4+1, shifting left with the feedback bit entering at [0]
      lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          state_d = S_WAIT;
          cnt_d   = lfsr_q[WAIT_W-1:0];
        end
      end
      S_WAIT: begin
        req_ready = (cnt_q == '0);
        if (!bus.req_valid_i) begin
          // requester withdrew: abandon without touching memory
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else if (bus.req_rnw_i) begin
          state_d = S_RESP;
          rdata_d = addr_ok ? mem[bus.req_addr_i] : '0;
          err_d   = !addr_ok;
        end else begin
          state_d = S_IDLE;
          wr_en   = addr_ok;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready_i) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // storage is deliberately not reset; wr_en is low whenever the FSM sits in reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
`ifdef MEMIF_BYTE_STROBE_EN
      for (int b = 0; b < DATA_W/8; b++) begin
        if (bus.req_wstrb_i[b]) mem[bus.req_addr_i][8*b +: 8] <= bus.req_wdata_i[8*b +: 8];
      end
`else
      mem[bus.req_addr_i] <= bus.req_wdata_i;
`endif
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_mem_req_rsp_ctrl.sv
// Randomised bench for mem_req_rsp_ctrl against a word-array memory model and LFSR sequence.
module tb_mem_req_rsp_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;
  localparam int WAIT_W = 2;
  localparam int NB     = DATA_W/8;
  localparam logic [7:0] SEED = 8'hE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;

  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [7:0]        lfsr_m;

  mem_req_rsp_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_req_rsp_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference pseudo-random sequence: next bit = b7^b5^b4^b3 appended at the bottom
  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_m <= SEED;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] apply_write(input logic [DATA_W-1:0] old_w,
      input logic [DATA_W-1:0] new_w, input logic [NB-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < NB; b++) begin
`ifdef MEMIF_BYTE_STROBE_EN
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
`else
      r[8*b +: 8] = new_w[8*b +: 8];
`endif
    end
    return r;
  endfunction

  // driver: one complete request, starting and ending on a falling edge with the DUT idle
  task automatic do_req(input logic rnw, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [NB-1:0] strb,
                        input int hold);
    int n;
    int exp_wait;
    logic [DATA_W-1:0] exp_data;
    bus.req_valid_i = 1'b1;
    bus.req_rnw_i   = rnw;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
`ifdef MEMIF_BYTE_STROBE_EN
    bus.req_wstrb_i = strb;
`endif
    exp_wait = int'(lfsr_m[WAIT_W-1:0]);
    check_eq("ready_in_idle", bus.req_ready_o, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready_o && n < 16);
    check_eq("wait_cycles", n, exp_wait + 1);
    if (!bus.req_ready_o) begin
      bus.req_valid_i = 1'b0;
      repeat (6) @(negedge clk);
      return;
    end
    if (!rnw) begin
      if (int'(addr) < DEPTH) mem_m[addr] = apply_write(mem_m[addr], wdata, strb);
    end else begin
      exp_q.push_back((int'(addr) < DEPTH) ? mem_m[addr] : '0);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check_eq("ready_after_accept", bus.req_ready_o, 0);
    if (!rnw) begin
      check_eq("no_rsp_on_write", bus.rsp_valid_o, 0);
      return;
    end
    exp_data = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check_eq("rsp_valid_held", bus.rsp_valid_o, 1);
      check_eq("rsp_rdata_held", bus.rsp_rdata_o, exp_data);
      @(negedge clk);
    end
    check_eq("rsp_valid", bus.rsp_valid_o, 1);
    check_eq("rsp_rdata", bus.rsp_rdata_o, exp_data);
    check_eq("rsp_err", bus.rsp_err_o, (int'(addr) >= DEPTH) ? 1 : 0);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check_eq("rsp_released", bus.rsp_valid_o, 0);
  endtask

  // request abandoned by the requester one cycle in
  task automatic abort_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bus.req_valid_i = 1'b1;
    bus.req_rnw_i   = 1'b0;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
`ifdef MEMIF_BYTE_STROBE_EN
    bus.req_wstrb_i = '1;
`endif
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_idle_ready", bus.req_ready_o, 0);
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_rnw_i   = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;
`ifdef MEMIF_BYTE_STROBE_EN
    bus.req_wstrb_i = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_req_ready", bus.req_ready_o, 0);
      check_eq("rst_rsp_valid", bus.rsp_valid_o, 0);
      check_eq("rst_rsp_err", bus.rsp_err_o, 0);
      check_eq("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    end

    // give every word a known value
    for (int a = 0; a < DEPTH; a++) do_req(1'b0, ADDR_W'(a), $urandom, '1, 0);

    do_req(1'b0, 4'd3, 32'hDEADBEEF, '1, 0);
    do_req(1'b1, 4'd3, '0, '0, 0);
    do_req(1'b1, 4'd5, '0, '0, 4);
    do_req(1'b0, 4'd13, 32'h0000_1234, '1, 0);
    do_req(1'b1, 4'd13, '0, '0, 0);
    do_req(1'b1, 4'd15, '0, '0, 1);
    for (int a = 0; a < DEPTH; a++) do_req(1'b1, ADDR_W'(a), '0, '0, 0);

    do_req(1'b0, 4'd2, 32'hFFFF_FFFF, 4'hF, 0);
    do_req(1'b0, 4'd2, 32'h0000_0000, 4'b0101, 0);
    do_req(1'b1, 4'd2, '0, '0, 0);

    abort_write(4'd4, 32'h5555_5555);
    do_req(1'b1, 4'd4, '0, '0, 0);

    // reset while a write to @7 is still waiting: the old word must survive
    do_req(1'b0, 4'd7, 32'h0000_00A5, '1, 0);
    bus.req_valid_i = 1'b1;
    bus.req_rnw_i   = 1'b0;
    bus.req_addr_i  = 4'd7;
    bus.req_wdata_i = 32'h0BAD_0BAD;
`ifdef MEMIF_BYTE_STROBE_EN
    bus.req_wstrb_i = '1;
`endif
    @(negedge clk);
    reset = 1'b1;
    #1 check_eq("rst_mid_ready", bus.req_ready_o, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid_i = 1'b0;
    check_eq("rst_mid_rsp_valid", bus.rsp_valid_o, 0);
    do_req(1'b1, 4'd7, '0, '0, 0);

    for (int i = 0; i < 80; i++) begin
      do_req(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), $urandom,
             NB'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
